// File: rtl/ssd_mux.sv
// ssd_mux: time-multiplexed seven-segment driver for NUM_DIGITS hex digits.
// Each digit dwells DIV = CLK_FREQ_HZ/REFRESH_HZ cycles. The first BLANK_CYCLES
// cycles of every dwell keep all anodes dark so the previous digit's segments
// cannot ghost onto the next one. Inputs are captured once per frame, so a
// frame never mixes old and new values.
// Optional feature: define SSD_ZERO_BLANK_EN to suppress leading zero digits.
module ssd_mux #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   val,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [6:0]                cat,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Level that means "off" on every output pin.
    localparam logic OFF = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      tick;
    logic                      frame_end;

    logic [4*NUM_DIGITS-1:0]   val_snap_q;
    logic [NUM_DIGITS-1:0]     dp_snap_q;
    logic [NUM_DIGITS-1:0]     en_snap_q;

    logic [NUM_DIGITS-1:0]     zb;
    logic [NUM_DIGITS-1:0]     sel_onehot;
    logic [3:0]                sel_nib;
    logic                      sel_en;
    logic                      sel_dp;
    logic                      sel_zb;
    logic                      lit;

    logic [6:0]                cat_q;
    logic                      dp_out_q;
    logic [NUM_DIGITS-1:0]     an_q;

    // Segment pattern {g,f,e,d,c,b,a}, 1 = segment on.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign tick      = (cnt_q == CNT_W'(DIV - 1));
    assign frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Dwell counter and digit index next-state.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Frame-coherent snapshot of the display inputs, taken at the end of the last dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_snap_q <= '0;
            dp_snap_q  <= '0;
            en_snap_q  <= '0;
        end else if (frame_end) begin
            val_snap_q <= val;
            dp_snap_q  <= dp;
            en_snap_q  <= digit_en;
        end
    end

`ifdef SSD_ZERO_BLANK_EN
    logic all_zero;

    // Leading-zero mask: digit k dark when it and every digit above it are zero.
    always_comb begin
        zb       = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (val_snap_q[4*k +: 4] == 4'h0);
            zb[k]    = all_zero;
        end
    end
`else
    // No suppression: every enabled digit shows its nibble.
    always_comb begin
        zb = '0;
    end
`endif

    // Pick out the snapshot fields of the digit currently being scanned.
    always_comb begin
        sel_onehot = '0;
        sel_nib    = '0;
        sel_en     = 1'b0;
        sel_dp     = 1'b0;
        sel_zb     = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_nib       = val_snap_q[4*k +: 4];
                sel_en        = en_snap_q[k];
                sel_dp        = dp_snap_q[k];
                sel_zb        = zb[k];
            end
        end
    end

    assign lit = (cnt_q >= CNT_W'(BLANK_CYCLES)) && sel_en && !sel_zb;

    // Registered outputs; reset forces every pin to its off level without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q     <= {NUM_DIGITS{OFF}};
            cat_q    <= {7{OFF}};
            dp_out_q <= OFF;
        end else if (lit) begin
            an_q     <= sel_onehot ^ {NUM_DIGITS{OFF}};
            cat_q    <= hex_seg(sel_nib) ^ {7{OFF}};
            dp_out_q <= sel_dp ^ OFF;
        end else begin
            an_q     <= {NUM_DIGITS{OFF}};
            cat_q    <= {7{OFF}};
            dp_out_q <= OFF;
        end
    end

    assign an     = an_q;
    assign cat    = cat_q;
    assign dp_out = dp_out_q;

endmodule

// File: tb/tb_ssd_mux.sv
// tb_ssd_mux: randomized and directed bench for ssd_mux (4 digits, DIV=10, 2 dead cycles,
// active-low pins). The reference model derives the expected pins from the number of
// clock edges since reset release and a per-frame copy of the inputs.
module tb_ssd_mux;

    localparam int NUM   = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = NUM * DIV;

    logic              clk;
    logic              rst_n;
    logic [4*NUM-1:0]  val;
    logic [NUM-1:0]    dp;
    logic [NUM-1:0]    digit_en;
    logic [6:0]        cat;
    logic              dp_out;
    logic [NUM-1:0]    an;

    int n_checks;
    int n_fail;
    int n_edge;        // clock edges since reset release

    // Model copy of the displayed frame.
    logic [4*NUM-1:0]  m_val;
    logic [NUM-1:0]    m_dp;
    logic [NUM-1:0]    m_en;

    logic [6:0] seg_tab [16];

    ssd_mux #(
        .NUM_DIGITS   (NUM),
        .CLK_FREQ_HZ  (1000),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (BLANK),
        .ACTIVE_LOW   (1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .val      (val),
        .dp       (dp),
        .digit_en (digit_en),
        .cat      (cat),
        .dp_out   (dp_out),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n_edge);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [4*NUM-1:0] v, input int k);
        return 4'((v >> (4 * k)) & 16'hF);
    endfunction

    function automatic bit zero_blanked(input int k);
`ifdef SSD_ZERO_BLANK_EN
        if (k == 0) return 1'b0;
        for (int j = k; j < NUM; j++) begin
            if (nib_of(m_val, j) != 4'h0) return 1'b0;
        end
        return 1'b1;
`else
        return (k < 0);
`endif
    endfunction

    // Advance k clocks, checking every output against the model after each edge.
    task automatic run_cycles(input int k);
        int  c;
        int  d;
        bit  on;
        logic [NUM-1:0] e_an;
        logic [6:0]     e_cat;
        logic           e_dp;
        repeat (k) begin
            @(posedge clk);
            n_edge++;
            // Pins after this edge reflect the scan position before it.
            c  = (n_edge - 1) % DIV;
            d  = ((n_edge - 1) / DIV) % NUM;
            on = (c >= BLANK) && m_en[d] && !zero_blanked(d);
            e_an  = on ? ~(NUM'(1) << d) : '1;
            e_cat = on ? ~seg_tab[nib_of(m_val, d)] : 7'h7F;
            e_dp  = on ? ~m_dp[d] : 1'b1;
            if (n_edge % FRAME == 0) begin
                m_val = val;
                m_dp  = dp;
                m_en  = digit_en;
            end
            #1;
            check("an", 32'(an), 32'(e_an));
            check("cat", 32'(cat), 32'(e_cat));
            check("dp_out", 32'(dp_out), 32'(e_dp));
            check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        end
    endtask

    // Assert reset between edges, confirm pins go off at once and stay off, then release.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_cat", 32'(cat), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_an", 32'(an), 32'hF);
        @(negedge clk);
        rst_n  = 1'b1;
        n_edge = 0;
        m_val  = '0;
        m_dp   = '0;
        m_en   = '0;
    endtask

    task automatic randomize_inputs();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 4))
            0: v = v & 16'h00FF;
            1: v = v & 16'h000F;
            2: v = 16'h0;
            3: v = v & 16'h0F0F;
            default: ;
        endcase
        val      = v;
        dp       = 4'($urandom);
        digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        n_checks = 0;
        n_fail   = 0;
        n_edge   = 0;
        rst_n    = 1'b1;
        val      = '0;
        dp       = '0;
        digit_en = '0;
        #3;
        apply_reset();

        // Scan order and timing with 1234 / all enabled / dp on digit 0.
        val      = 16'h1234;
        digit_en = 4'hF;
        dp       = 4'b0001;
        run_cycles(42);
        check("dead_time_an", 32'(an), 32'hF);
        run_cycles(1);
        check("d0_an", 32'(an), 32'b1110);
        check("d0_cat", 32'(cat), 32'b0011001);
        check("d0_dp", 32'(dp_out), 32'd0);
        run_cycles(30);
        check("d3_an", 32'(an), 32'b0111);
        check("d3_cat", 32'(cat), 32'b1111001);

        // Coherence: new value while digit 1 is scanned is held off until next frame.
        run_cycles(19);
        val = 16'hABCD;
        run_cycles(21);
        check("coh_old_an", 32'(an), 32'b0111);
        check("coh_old_cat", 32'(cat), 32'b1111001);
        run_cycles(10);
        check("coh_new_cat", 32'(cat), 32'b0100001);

        // Enables: digits 1 and 3 stay dark for two full frames.
        digit_en = 4'b0101;
        run_cycles(2 * FRAME + 7);

        // Leading zeros (0050): shown or suppressed depending on build.
        val      = 16'h0050;
        dp       = 4'h0;
        digit_en = 4'hF;
        while (n_edge % FRAME != 0) run_cycles(1);
        run_cycles(FRAME + 5);
        check("zb_d0_cat", 32'(cat), 32'b1000000);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            randomize_inputs();
            run_cycles($urandom_range(3, 70));
        end

        // Mid-scan reset at cnt=5, idx=2, then a dark first frame.
        for (int g = 0; g < FRAME && !((n_edge % DIV == 5) && ((n_edge / DIV) % NUM == 2)); g++)
            run_cycles(1);
        check("midscan_pos", 32'((n_edge % DIV == 5) && ((n_edge / DIV) % NUM == 2)), 32'd1);
        apply_reset();
        run_cycles(5);
        check("post_rst_dark", 32'(an), 32'hF);
        run_cycles(FRAME);

        for (int it = 0; it < 30; it++) begin
            randomize_inputs();
            run_cycles($urandom_range(3, 70));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
